warp_dispatch_arbiter: RTL and testbench

Sits between `warp_scheduler` and the SIMD cores. Buffers launched kernels (`kernel_t`) in a small FIFO and issues each one to a free core, picking cores round-robin. It tracks per-core occupancy and reports each completed warp back to `warp_scheduler` on `finished_warp_id`, one per cycle. It is the single owner of the core-busy state.

---
 rtl/warp_dispatch_arbiter_pkg.sv | 12 +
 rtl/warp_dispatch_arbiter_rr_pick.sv | 24 ++
 rtl/warp_dispatch_arbiter.sv | 92 +++++++++
 tb/tb_warp_dispatch_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/warp_dispatch_arbiter_pkg.sv
// warp_dispatch_arbiter_pkg: shared kernel descriptor, core state and dispatch constants.
package warp_dispatch_arbiter_pkg;
  localparam int LOG2_THREAD_COUNT = 3;
  localparam int DISPATCH_FIFO_DEPTH = 4;
  localparam logic [3:0] NO_WARP = 4'hF;
  typedef struct packed {
    logic [3:0] warp_id;
    logic [LOG2_THREAD_COUNT-1:0] num_threads;
    logic [31:0] pc;
  } kernel_t;
  typedef enum logic [1:0] {IDLE, RUNNING, DONE_PEND} core_state_t;
endpackage

// File: rtl/warp_dispatch_arbiter_rr_pick.sv
// rr_pick: first set bit of mask at or after start, wrapping, as one-hot grant plus index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] pos [N];
  genvar g;
  for (g = 0; g < N; g++) begin : g_pos
    assign pos[g] = W'((int'(start) + g) % N);
  end
  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (mask[pos[i]]) idx = pos[i];
    any = |mask;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/warp_dispatch_arbiter.sv
// warp_dispatch_arbiter: buffers kernels, issues them round-robin to idle cores and reports retired warps.
module warp_dispatch_arbiter
  import warp_dispatch_arbiter_pkg::*;
#(
  parameter int NUM_SIMD_CORES = 4,
  parameter int FIFO_DEPTH = DISPATCH_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_kernel,
  input  kernel_t                   kernel_in,
  input  logic [NUM_SIMD_CORES-1:0] core_done,
  output logic                      kernel_ready,
  output logic [NUM_SIMD_CORES-1:0] core_issue,
  output kernel_t                   core_kernel,
  output logic [3:0]                finished_warp_id,
  output logic [NUM_SIMD_CORES-1:0] busy_mask,
  output logic                      err
);
  localparam int CW = (NUM_SIMD_CORES > 1) ? $clog2(NUM_SIMD_CORES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  kernel_t mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [NW-1:0] count;
  core_state_t state [NUM_SIMD_CORES];
  core_state_t state_nx [NUM_SIMD_CORES];
  logic [3:0] wid [NUM_SIMD_CORES];
  logic [CW-1:0] issue_rr, rpt_rr, issue_k, rpt_k;
  logic [NUM_SIMD_CORES-1:0] idle_mask, pend_mask, issue_grant, rpt_grant;
  logic issue_any, rpt_any, push, pop, err_nx;
  genvar g;
  for (g = 0; g < NUM_SIMD_CORES; g++) begin : g_mask
    assign idle_mask[g] = state[g] == IDLE;
    assign pend_mask[g] = state[g] == DONE_PEND;
    assign busy_mask[g] = state[g] != IDLE;
  end
  assign kernel_ready = count != NW'(FIFO_DEPTH);
  assign push = valid_kernel && kernel_ready && kernel_in.warp_id != NO_WARP;
  assign pop = count != '0 && issue_any;
  rr_pick #(.N(NUM_SIMD_CORES), .W(CW)) u_issue_pick (
    .mask(idle_mask), .start(issue_rr), .grant(issue_grant), .idx(issue_k), .any(issue_any)
  );
  rr_pick #(.N(NUM_SIMD_CORES), .W(CW)) u_rpt_pick (
    .mask(pend_mask), .start(rpt_rr), .grant(rpt_grant), .idx(rpt_k), .any(rpt_any)
  );
  // A done pulse on a core that is not running is a protocol error, including a core being issued this cycle.
  always_comb begin
    state_nx = state;
    err_nx = err | (valid_kernel && (!kernel_ready || kernel_in.warp_id == NO_WARP));
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      if (pop && issue_grant[i]) state_nx[i] = RUNNING;
      if (core_done[i]) begin
        if (state[i] == RUNNING) state_nx[i] = DONE_PEND;
        else err_nx = 1'b1;
      end
      if (rpt_grant[i]) state_nx[i] = IDLE;
    end
  end
  always_ff @(posedge clk) if (push) mem[tail] <= kernel_in;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      issue_rr <= '0;
      rpt_rr <= '0;
      core_issue <= '0;
      core_kernel <= '0;
      finished_warp_id <= NO_WARP;
      err <= 1'b0;
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        state[i] <= IDLE;
        wid[i] <= '0;
      end
    end else begin
      state <= state_nx;
      err <= err_nx;
      count <= count + NW'(push) - NW'(pop);
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head <= head + 1'b1;
        core_kernel <= mem[head];
        issue_rr <= (issue_k == CW'(NUM_SIMD_CORES - 1)) ? '0 : issue_k + 1'b1;
      end
      core_issue <= pop ? issue_grant : '0;
      if (rpt_any) rpt_rr <= (rpt_k == CW'(NUM_SIMD_CORES - 1)) ? '0 : rpt_k + 1'b1;
      finished_warp_id <= rpt_any ? wid[rpt_k] : NO_WARP;
      for (int i = 0; i < NUM_SIMD_CORES; i++) if (pop && issue_grant[i]) wid[i] <= mem[head].warp_id;
    end
  end
endmodule

// File: tb/tb_warp_dispatch_arbiter.sv
// tb_warp_dispatch_arbiter: directed scenarios with hand-computed expectations for the dispatch arbiter.
module tb_warp_dispatch_arbiter;
  import warp_dispatch_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_kernel = 1'b0;
  kernel_t kernel_in = '0;
  logic [3:0] core_done = '0;
  logic kernel_ready, err;
  logic [3:0] core_issue, busy_mask, finished_warp_id;
  kernel_t core_kernel;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  warp_dispatch_arbiter dut (
    .clk(clk), .rst(rst), .valid_kernel(valid_kernel), .kernel_in(kernel_in), .core_done(core_done),
    .kernel_ready(kernel_ready), .core_issue(core_issue), .core_kernel(core_kernel),
    .finished_warp_id(finished_warp_id), .busy_mask(busy_mask), .err(err)
  );

  function automatic kernel_t mk(input logic [3:0] id, input logic [2:0] nt, input logic [31:0] pc);
    kernel_t k;
    k.warp_id = id;
    k.num_threads = nt;
    k.pc = pc;
    return k;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b0;
    valid_kernel = 1'b0;
    core_done = '0;
    tick;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic push_cycle(input kernel_t k);
    valid_kernel = 1'b1;
    kernel_in = k;
    tick;
    valid_kernel = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    tick;
    vecs++; if (finished_warp_id !== 4'hF) begin errs++; $display("FAIL reset_fwid got %h want f", finished_warp_id); end
    vecs++; if (kernel_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", kernel_ready); end
    vecs++; if (busy_mask !== 4'b0000) begin errs++; $display("FAIL reset_busy got %b want 0000", busy_mask); end
    vecs++; if (core_issue !== 4'b0000) begin errs++; $display("FAIL reset_issue got %b want 0000", core_issue); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
    vecs++; if (core_kernel !== kernel_t'(0)) begin errs++; $display("FAIL reset_kernel got %h want 0", core_kernel); end
    rst = 1'b1;
    repeat (5) tick;
    vecs++; if (finished_warp_id !== 4'hF) begin errs++; $display("FAIL idle_fwid got %h want f", finished_warp_id); end
    vecs++; if (busy_mask !== 4'b0000 || core_issue !== 4'b0000) begin errs++; $display("FAIL idle_busy_issue got %b/%b want 0000/0000", busy_mask, core_issue); end
    vecs++; if (kernel_ready !== 1'b1) begin errs++; $display("FAIL idle_ready got %b want 1", kernel_ready); end
  endtask

  task automatic test_three_kernels;
    valid_kernel = 1'b1;
    kernel_in = mk(4'd0, 3'd4, 32'hFFFF_FFFE);
    tick;
    vecs++; if (core_issue !== 4'b0000) begin errs++; $display("FAIL three_nobypass got %b want 0000", core_issue); end
    kernel_in = mk(4'd1, 3'd2, 32'h8765_4321);
    tick;
    vecs++; if (core_issue !== 4'b0001) begin errs++; $display("FAIL three_issue0 got %b want 0001", core_issue); end
    vecs++; if (core_kernel !== mk(4'd0, 3'd4, 32'hFFFF_FFFE)) begin errs++; $display("FAIL three_kernel0 got %h want %h", core_kernel, mk(4'd0, 3'd4, 32'hFFFF_FFFE)); end
    kernel_in = mk(4'd2, 3'd7, 32'hABCD_EF01);
    tick;
    valid_kernel = 1'b0;
    vecs++; if (core_issue !== 4'b0010) begin errs++; $display("FAIL three_issue1 got %b want 0010", core_issue); end
    vecs++; if (core_kernel !== mk(4'd1, 3'd2, 32'h8765_4321)) begin errs++; $display("FAIL three_kernel1 got %h want %h", core_kernel, mk(4'd1, 3'd2, 32'h8765_4321)); end
    tick;
    vecs++; if (core_issue !== 4'b0100) begin errs++; $display("FAIL three_issue2 got %b want 0100", core_issue); end
    vecs++; if (core_kernel !== mk(4'd2, 3'd7, 32'hABCD_EF01)) begin errs++; $display("FAIL three_kernel2 got %h want %h", core_kernel, mk(4'd2, 3'd7, 32'hABCD_EF01)); end
    vecs++; if (busy_mask !== 4'b0111) begin errs++; $display("FAIL three_busy got %b want 0111", busy_mask); end
    tick;
    vecs++; if (core_issue !== 4'b0000 || busy_mask !== 4'b0111) begin errs++; $display("FAIL three_settle got %b/%b want 0000/0111", core_issue, busy_mask); end
  endtask

  task automatic test_round_robin_wrap;
    core_done = 4'b0001;
    tick;
    core_done = '0;
    vecs++; if (finished_warp_id !== 4'hF) begin errs++; $display("FAIL rr_pend_fwid got %h want f", finished_warp_id); end
    tick;
    vecs++; if (finished_warp_id !== 4'd0) begin errs++; $display("FAIL rr_report got %h want 0", finished_warp_id); end
    vecs++; if (busy_mask !== 4'b0110) begin errs++; $display("FAIL rr_busy got %b want 0110", busy_mask); end
    push_cycle(mk(4'd5, 3'd1, 32'h0000_1000));
    vecs++; if (finished_warp_id !== 4'hF) begin errs++; $display("FAIL rr_report_once got %h want f", finished_warp_id); end
    push_cycle(mk(4'd6, 3'd3, 32'h0000_2000));
    vecs++; if (core_issue !== 4'b1000) begin errs++; $display("FAIL rr_issue3 got %b want 1000", core_issue); end
    vecs++; if (core_kernel.warp_id !== 4'd5) begin errs++; $display("FAIL rr_kernel3 got %h want 5", core_kernel.warp_id); end
    tick;
    vecs++; if (core_issue !== 4'b0001) begin errs++; $display("FAIL rr_issue0 got %b want 0001", core_issue); end
    vecs++; if (core_kernel !== mk(4'd6, 3'd3, 32'h0000_2000)) begin errs++; $display("FAIL rr_kernel0 got %h want %h", core_kernel, mk(4'd6, 3'd3, 32'h0000_2000)); end
    vecs++; if (busy_mask !== 4'b1111) begin errs++; $display("FAIL rr_busy_full got %b want 1111", busy_mask); end
  endtask

  task automatic test_back_pressure;
    for (int i = 0; i < 4; i++) begin
      push_cycle(mk(4'(7 + i), 3'd1, 32'h100 * (7 + i)));
      if (i == 2) begin
        vecs++; if (kernel_ready !== 1'b1) begin errs++; $display("FAIL bp_ready3 got %b want 1", kernel_ready); end
      end
    end
    vecs++; if (kernel_ready !== 1'b0) begin errs++; $display("FAIL bp_full got %b want 0", kernel_ready); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL bp_err_early got %b want 0", err); end
    push_cycle(mk(4'd11, 3'd1, 32'h0000_0B00));
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL bp_overflow_err got %b want 1", err); end
    vecs++; if (kernel_ready !== 1'b0 || core_issue !== 4'b0000) begin errs++; $display("FAIL bp_hold got %b/%b want 0/0000", kernel_ready, core_issue); end
    core_done = 4'b0100;
    tick;
    core_done = '0;
    vecs++; if (finished_warp_id !== 4'hF || busy_mask !== 4'b1111) begin errs++; $display("FAIL bp_pend got %h/%b want f/1111", finished_warp_id, busy_mask); end
    tick;
    vecs++; if (finished_warp_id !== 4'd2) begin errs++; $display("FAIL bp_report got %h want 2", finished_warp_id); end
    vecs++; if (busy_mask !== 4'b1011 || core_issue !== 4'b0000) begin errs++; $display("FAIL bp_freed got %b/%b want 1011/0000", busy_mask, core_issue); end
    tick;
    vecs++; if (core_issue !== 4'b0100) begin errs++; $display("FAIL bp_reissue got %b want 0100", core_issue); end
    vecs++; if (core_kernel !== mk(4'd7, 3'd1, 32'h0000_0700)) begin errs++; $display("FAIL bp_head got %h want %h", core_kernel, mk(4'd7, 3'd1, 32'h0000_0700)); end
    vecs++; if (kernel_ready !== 1'b1 || finished_warp_id !== 4'hF) begin errs++; $display("FAIL bp_after got %b/%h want 1/f", kernel_ready, finished_warp_id); end
  endtask

  task automatic test_simultaneous_done;
    reset_dut;
    valid_kernel = 1'b1;
    kernel_in = mk(4'd0, 3'd1, 32'h10);
    tick;
    kernel_in = mk(4'd1, 3'd1, 32'h20);
    tick;
    kernel_in = mk(4'd9, 3'd1, 32'h30);
    tick;
    kernel_in = mk(4'd3, 3'd1, 32'h40);
    tick;
    valid_kernel = 1'b0;
    tick;
    vecs++; if (busy_mask !== 4'b1111) begin errs++; $display("FAIL sim_busy got %b want 1111", busy_mask); end
    core_done = 4'b1011;
    tick;
    core_done = '0;
    vecs++; if (finished_warp_id !== 4'hF) begin errs++; $display("FAIL sim_pend got %h want f", finished_warp_id); end
    tick;
    vecs++; if (finished_warp_id !== 4'd0) begin errs++; $display("FAIL sim_rpt0 got %h want 0", finished_warp_id); end
    tick;
    vecs++; if (finished_warp_id !== 4'd1) begin errs++; $display("FAIL sim_rpt1 got %h want 1", finished_warp_id); end
    tick;
    vecs++; if (finished_warp_id !== 4'd3) begin errs++; $display("FAIL sim_rpt3 got %h want 3", finished_warp_id); end
    vecs++; if (busy_mask !== 4'b0100) begin errs++; $display("FAIL sim_busy_end got %b want 0100", busy_mask); end
    tick;
    vecs++; if (finished_warp_id !== 4'hF) begin errs++; $display("FAIL sim_none got %h want f", finished_warp_id); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL sim_err got %b want 0", err); end
  endtask

  task automatic test_errors_and_reset;
    reset_dut;
    core_done = 4'b0010;
    tick;
    core_done = '0;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_idle_done got %b want 1", err); end
    vecs++; if (busy_mask !== 4'b0000 || finished_warp_id !== 4'hF) begin errs++; $display("FAIL err_idle_state got %b/%h want 0000/f", busy_mask, finished_warp_id); end
    tick;
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b want 1", err); end
    reset_dut;
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_cleared got %b want 0", err); end
    push_cycle(mk(4'hF, 3'd2, 32'hDEAD_BEEF));
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_nowarp got %b want 1", err); end
    tick;
    vecs++; if (core_issue !== 4'b0000 || busy_mask !== 4'b0000) begin errs++; $display("FAIL err_nowarp_drop got %b/%b want 0000/0000", core_issue, busy_mask); end
    reset_dut;
    valid_kernel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      kernel_in = mk(4'(i), 3'd1, 32'(i));
      tick;
    end
    valid_kernel = 1'b0;
    core_done = 4'b0001;
    tick;
    core_done = '0;
    vecs++; if (busy_mask !== 4'b1111 || kernel_ready !== 1'b1) begin errs++; $display("FAIL mid_setup got %b/%b want 1111/1", busy_mask, kernel_ready); end
    rst = 1'b0;
    #1;
    vecs++; if (busy_mask !== 4'b0000 || finished_warp_id !== 4'hF || core_issue !== 4'b0000) begin errs++; $display("FAIL mid_async got %b/%h/%b want 0000/f/0000", busy_mask, finished_warp_id, core_issue); end
    tick;
    rst = 1'b1;
    repeat (4) begin
      tick;
      vecs++; if (core_issue !== 4'b0000 || finished_warp_id !== 4'hF) begin errs++; $display("FAIL mid_after got %b/%h want 0000/f", core_issue, finished_warp_id); end
    end
    vecs++; if (busy_mask !== 4'b0000 || kernel_ready !== 1'b1 || err !== 1'b0) begin errs++; $display("FAIL mid_final got %b/%b/%b want 0000/1/0", busy_mask, kernel_ready, err); end
  endtask

  initial begin
    test_reset;
    test_three_kernels;
    test_round_robin_wrap;
    test_back_pressure;
    test_simultaneous_done;
    test_errors_and_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
